// File: rtl/lcd_pattern_gen_if.sv
// rtl/lcd_pattern_gen_if.sv - pixel request/response bus between LCD timing controller and pattern source
interface lcd_pattern_gen_if;
  logic        lcd_vs;    // vertical sync, low during sync
  logic [11:0] lcd_xpos;  // look-ahead x, valid one clock before DE
  logic [11:0] lcd_ypos;  // look-ahead y, valid one clock before DE
  logic [23:0] lcd_data;  // RGB888 {R,G,B}, returned one clock later

  // timing controller side
  modport master (
    output lcd_vs,
    output lcd_xpos,
    output lcd_ypos,
    input  lcd_data
  );

  // pattern source side
  modport slave (
    input  lcd_vs,
    input  lcd_xpos,
    input  lcd_ypos,
    output lcd_data
  );
endinterface

// File: rtl/lcd_pattern_gen.sv
// rtl/lcd_pattern_gen.sv - LCD test pattern source (bars/grid/gradient/box), optional overlay PATTERN_CROSSHAIR_EN
module lcd_pattern_gen #(
  parameter int H_DISP          = 800,
  parameter int V_DISP          = 480,
  parameter int BOX_SIZE        = 64,
  parameter int BOX_STEP        = 2,
  parameter int DEBOUNCE_CYCLES = 800000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_key_n,
  lcd_pattern_gen_if.slave    lcd,
  output logic [1:0]          o_mode,
  output logic [15:0]         o_frame_cnt
);

  localparam int          CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int          BAR_W  = H_DISP / 8;
  localparam logic [11:0] X_MAX  = 12'(H_DISP - BOX_SIZE);
  localparam logic [11:0] Y_MAX  = 12'(V_DISP - BOX_SIZE);
  localparam logic [12:0] STEP13 = 13'(BOX_STEP);
  localparam logic [12:0] SIZE13 = 13'(BOX_SIZE);

  localparam logic [23:0] C_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] C_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] C_CYAN    = 24'h00FFFF;
  localparam logic [23:0] C_GREEN   = 24'h00FF00;
  localparam logic [23:0] C_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] C_RED     = 24'hFF0000;
  localparam logic [23:0] C_BLUE    = 24'h0000FF;
  localparam logic [23:0] C_BLACK   = 24'h000000;

  typedef enum logic {DIR_POS = 1'b0, DIR_NEG = 1'b1} dir_t;

  logic             r_vs_d;
  logic             w_tick;
  logic             r_key_s1;
  logic             r_key_s2;
  logic             r_key_stable;
  logic [CNT_W-1:0] r_db_cnt;
  logic             w_db_done;
  logic             w_press;
  logic [1:0]       r_mode_pending;
  logic [1:0]       r_mode;
  logic [15:0]      r_frame_cnt;
  logic [11:0]      r_bx;
  logic [11:0]      r_by;
  dir_t             r_dx;
  dir_t             r_dy;
  logic [11:0]      w_bx_next;
  logic [11:0]      w_by_next;
  dir_t             w_dx_next;
  dir_t             w_dy_next;
  logic [23:0]      w_bar;
  logic [23:0]      w_grid;
  logic [23:0]      w_grad;
  logic [23:0]      w_box;
  logic [23:0]      w_pixel;
  logic [11:0]      w_x;
  logic [11:0]      w_y;

  assign w_x    = lcd.lcd_xpos;
  assign w_y    = lcd.lcd_ypos;
  // a rising lcd_vs marks the end of vertical sync, i.e. the start of a new frame
  assign w_tick = lcd.lcd_vs & ~r_vs_d;

  // vs edge detector; reset high so a vs already high at release gives no spurious tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_vs_d <= 1'b1;
    else        r_vs_d <= lcd.lcd_vs;
  end

  // two-flop synchroniser for the asynchronous button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_s1 <= 1'b1;
      r_key_s2 <= 1'b1;
    end else begin
      r_key_s1 <= i_key_n;
      r_key_s2 <= r_key_s1;
    end
  end

  assign w_db_done = (r_key_s2 != r_key_stable) && (r_db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign w_press   = w_db_done && r_key_stable && !r_key_s2;

  // debounce: the level must differ from the stable level for the full window before it is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_cnt     <= '0;
      r_key_stable <= 1'b1;
    end else if (r_key_s2 == r_key_stable) begin
      r_db_cnt <= '0;
    end else if (w_db_done) begin
      r_db_cnt     <= '0;
      r_key_stable <= r_key_s2;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  // mode selection queues on a press and becomes visible only at the next frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_pending <= 2'd0;
      r_mode         <= 2'd0;
      r_frame_cnt    <= 16'd0;
    end else begin
      if (w_press) r_mode_pending <= r_mode_pending + 2'd1;
      if (w_tick) begin
        r_mode      <= r_mode_pending;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  // box position and direction state, advanced once per frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bx <= 12'd0;
      r_by <= 12'd0;
      r_dx <= DIR_POS;
      r_dy <= DIR_POS;
    end else if (w_tick) begin
      r_bx <= w_bx_next;
      r_by <= w_by_next;
      r_dx <= w_dx_next;
      r_dy <= w_dy_next;
    end
  end

  // bounce next-state: clamp to the edge so the box lands exactly on it before reversing
  always_comb begin
    w_bx_next = r_bx;
    w_by_next = r_by;
    w_dx_next = r_dx;
    w_dy_next = r_dy;
    case (r_dx)
      DIR_POS: begin
        if ({1'b0, r_bx} + STEP13 >= {1'b0, X_MAX}) begin
          w_bx_next = X_MAX;
          w_dx_next = DIR_NEG;
        end else begin
          w_bx_next = r_bx + 12'(BOX_STEP);
        end
      end
      default: begin
        if ({1'b0, r_bx} <= STEP13) begin
          w_bx_next = 12'd0;
          w_dx_next = DIR_POS;
        end else begin
          w_bx_next = r_bx - 12'(BOX_STEP);
        end
      end
    endcase
    case (r_dy)
      DIR_POS: begin
        if ({1'b0, r_by} + STEP13 >= {1'b0, Y_MAX}) begin
          w_by_next = Y_MAX;
          w_dy_next = DIR_NEG;
        end else begin
          w_by_next = r_by + 12'(BOX_STEP);
        end
      end
      default: begin
        if ({1'b0, r_by} <= STEP13) begin
          w_by_next = 12'd0;
          w_dy_next = DIR_POS;
        end else begin
          w_by_next = r_by - 12'(BOX_STEP);
        end
      end
    endcase
  end

  // colour bars by constant threshold compares, avoiding a divider
  always_comb begin
    w_bar = C_BLACK;
    if      (w_x >= 12'(H_DISP))    w_bar = C_BLACK;
    else if (w_x <  12'(BAR_W))     w_bar = C_WHITE;
    else if (w_x <  12'(2 * BAR_W)) w_bar = C_YELLOW;
    else if (w_x <  12'(3 * BAR_W)) w_bar = C_CYAN;
    else if (w_x <  12'(4 * BAR_W)) w_bar = C_GREEN;
    else if (w_x <  12'(5 * BAR_W)) w_bar = C_MAGENTA;
    else if (w_x <  12'(6 * BAR_W)) w_bar = C_RED;
    else if (w_x <  12'(7 * BAR_W)) w_bar = C_BLUE;
    else                            w_bar = C_BLACK;
  end

  assign w_grid = ((w_x[4:0] == 5'd0) || (w_y[4:0] == 5'd0) ||
                   (w_x == 12'(H_DISP - 1)) || (w_y == 12'(V_DISP - 1))) ? C_WHITE : C_BLACK;
  assign w_grad = {w_x[9:2], w_y[8:1], 8'h80};
  assign w_box  = ((w_x >= r_bx) && ({1'b0, w_x} < {1'b0, r_bx} + SIZE13) &&
                   (w_y >= r_by) && ({1'b0, w_y} < {1'b0, r_by} + SIZE13)) ? C_RED : C_BLUE;

  // pattern mux plus optional centre crosshair overlay
  always_comb begin
    w_pixel = w_bar;
    case (r_mode)
      2'd0:    w_pixel = w_bar;
      2'd1:    w_pixel = w_grid;
      2'd2:    w_pixel = w_grad;
      default: w_pixel = w_box;
    endcase
`ifdef PATTERN_CROSSHAIR_EN
    if ((w_x == 12'(H_DISP / 2)) || (w_y == 12'(V_DISP / 2))) w_pixel = C_WHITE;
`endif
  end

  // single output register: pixel lands one clock after its look-ahead coordinate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lcd.lcd_data <= 24'd0;
    else        lcd.lcd_data <= w_pixel;
  end

  assign o_mode      = r_mode;
  assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// tb/tb_lcd_pattern_gen.sv - directed self-checking bench for lcd_pattern_gen
module tb_lcd_pattern_gen;

  logic        clk;
  logic        rst_n;
  logic        key_n;
  logic [1:0]  mode;
  logic [15:0] frame_cnt;
  int          checks;
  int          failures;
  logic [23:0] cross_exp;

  lcd_pattern_gen_if lcd_bus ();

  lcd_pattern_gen #(.DEBOUNCE_CYCLES(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_key_n     (key_n),
    .lcd         (lcd_bus),
    .o_mode      (mode),
    .o_frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // drive a coordinate, let one clock pass, check the registered pixel
  task automatic pix(input string tag, input int x, input int y, input logic [23:0] exp);
    @(negedge clk);
    lcd_bus.lcd_xpos = 12'(x);
    lcd_bus.lcd_ypos = 12'(y);
    @(posedge clk);
    #1;
    check(tag, {8'h0, lcd_bus.lcd_data}, {8'h0, exp});
  endtask

  task automatic tick();
    @(negedge clk);
    lcd_bus.lcd_vs = 1'b0;
    @(negedge clk);
    lcd_bus.lcd_vs = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic key_low(input int n);
    @(negedge clk);
    key_n = 1'b0;
    repeat (n) @(negedge clk);
    key_n = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    rst_n            = 1'b0;
    key_n            = 1'b1;
    lcd_bus.lcd_vs   = 1'b1;
    lcd_bus.lcd_xpos = 12'd900;
    lcd_bus.lcd_ypos = 12'd0;
`ifdef PATTERN_CROSSHAIR_EN
    cross_exp = 24'hFFFFFF;
`else
    cross_exp = 24'h0000FF;
`endif

    // reset state
    repeat (4) @(negedge clk);
    check("rst_data", {8'h0, lcd_bus.lcd_data}, 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rel_data", {8'h0, lcd_bus.lcd_data}, 32'h0);
    check("rel_mode", {30'h0, mode}, 32'd0);
    check("rel_frame", {16'h0, frame_cnt}, 32'd0);

    // colour bars
    pix("bar_x0",   0,   10, 24'hFFFFFF);
    pix("bar_x100", 100, 10, 24'hFFFF00);
    pix("bar_x799", 799, 10, 24'h000000);
    pix("bar_x99",  99,  10, 24'hFFFFFF);
    pix("bar_x250", 250, 10, 24'h00FFFF);
    pix("bar_x450", 450, 10, 24'hFF00FF);
    pix("bar_x699", 699, 10, 24'h0000FF);
    pix("bar_x800", 800, 10, 24'h000000);

    // frame ticks; vs held high must not retrigger
    ticks(3);
    check("frame3", {16'h0, frame_cnt}, 32'd3);
    repeat (1000) @(negedge clk);
    check("frame_hold", {16'h0, frame_cnt}, 32'd3);

    // short glitch is rejected
    key_low(5);
    tick();
    check("glitch_mode", {30'h0, mode}, 32'd0);
    check("frame4", {16'h0, frame_cnt}, 32'd4);

    // real press only shows at the next frame
    key_low(40);
    check("press_wait", {30'h0, mode}, 32'd0);
    tick();
    check("press_mode1", {30'h0, mode}, 32'd1);
    key_low(40);
    key_low(40);
    tick();
    check("mode3", {30'h0, mode}, 32'd3);

    // after 6 ticks the box sits at (12,12)
    pix("box6_in",   12, 12, 24'hFF0000);
    pix("box6_left", 11, 12, 24'h0000FF);
    pix("box6_r_in", 75, 75, 24'hFF0000);
    pix("box6_r_out",76, 12, 24'h0000FF);
    pix("box6_bot",  12, 76, 24'h0000FF);
    pix("cross",     400, 10, cross_exp);

    // fourth press wraps to 0, then walk through grid and gradient
    key_low(40);
    tick();
    check("wrap_mode0", {30'h0, mode}, 32'd0);
    key_low(40);
    tick();
    check("mode1", {30'h0, mode}, 32'd1);
    pix("grid_x32",  32,  5,   24'hFFFFFF);
    pix("grid_x33",  33,  5,   24'h000000);
    pix("grid_x799", 799, 5,   24'hFFFFFF);
    pix("grid_y479", 33,  479, 24'hFFFFFF);
    pix("grid_y64",  33,  64,  24'hFFFFFF);
    pix("grid_31_63",31,  63,  24'h000000);
    key_low(40);
    tick();
    check("mode2", {30'h0, mode}, 32'd2);
    pix("grad_a", 676, 341, 24'hA9AA80);
    pix("grad_b", 3,   1,   24'h000080);
    key_low(40);
    tick();
    check("mode3b", {30'h0, mode}, 32'd3);
    check("frame10", {16'h0, frame_cnt}, 32'd10);

    // Y reaches 416 on tick 208 and reverses
    ticks(198);
    pix("y208_in",  416, 416, 24'hFF0000);
    pix("y208_out", 416, 415, 24'h0000FF);
    tick();
    pix("y209_in",  418, 414, 24'hFF0000);
    pix("y209_out", 418, 413, 24'h0000FF);

    // tick 368: bx=736 (right edge), by=96
    ticks(159);
    check("frame368", {16'h0, frame_cnt}, 32'd368);
    pix("t368_in",   736, 96, 24'hFF0000);
    pix("t368_xout", 735, 96, 24'h0000FF);
    pix("t368_yout", 736, 95, 24'h0000FF);
    pix("t368_edge", 799, 159, 24'hFF0000);
    tick();
    pix("t369_in",   734, 94, 24'hFF0000);
    pix("t369_xout", 733, 94, 24'h0000FF);
    pix("t369_r_in", 797, 94, 24'hFF0000);
    pix("t369_r_out",798, 94, 24'h0000FF);
    check("frame369", {16'h0, frame_cnt}, 32'd369);

    // asynchronous reset mid-cycle
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_data", {8'h0, lcd_bus.lcd_data}, 32'h0);
    check("arst_mode", {30'h0, mode}, 32'd0);
    check("arst_frame", {16'h0, frame_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_frame1", {16'h0, frame_cnt}, 32'd1);
    check("post_rst_mode0", {30'h0, mode}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
